// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and defaults for the sync_fifo read-side burst engine.
package fifo_burst_reader_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry {last,data} output buffer with registered head; push and pop may
// coincide in one cycle.
module fifo_rd_skid
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              push_last_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [1:0]        occ_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              head_last_o
);
  logic [1:0]      occ_q, occ_d;
  logic [DATA_W:0] head_q, head_d, tail_q, tail_d;
  logic [DATA_W:0] entry_in;
  logic            pop_ok;

  assign entry_in = {push_last_i, push_data_i};
  assign pop_ok   = pop_i && (occ_q != 2'd0);

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push_i, pop_ok})
      2'b10: begin
        if (occ_q == 2'd0) head_d = entry_in;
        else               tail_d = entry_in;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop: the new entry lands behind whatever remains.
        if (occ_q == 2'd1) head_d = entry_in;
        else begin
          head_d = tail_q;
          tail_d = entry_in;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign occ_o       = occ_q;
  assign head_data_o = head_q[DATA_W-1:0];
  assign head_last_o = head_q[DATA_W];
endmodule

// File: rtl/fifo_burst_reader.sv
// Pops sync_fifo entries and frames them as valid/ready bursts with m_last,
// triggered by a full burst queued or a partial queue timing out.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_cnt,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy
);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] BLEN = CNT_W'(BURST_LEN);
  localparam logic [TMR_W-1:0] TMO  = TMR_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic             inflight_q;
  logic [1:0]       occ, occ_adj;
  logic             beat_acc, cap_last;

  assign m_valid  = (occ != 2'd0);
  assign beat_acc = m_valid && m_ready;
  // Buffer room as seen next cycle: the beat leaving now frees a slot, the
  // pop already in flight will take one.
  assign occ_adj  = occ - {1'b0, beat_acc} + {1'b0, inflight_q};
  // Only one pop can be in flight, so the captured beat's index is issued-1.
  assign cap_last = (issued_q == len_q);
  assign busy     = (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    len_d    = len_q;
    issued_d = issued_q;
    sent_d   = sent_q;
    fifo_rd  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_empty)          timer_d = '0;
        else if (timer_q != TMO) timer_d = timer_q + TMR_W'(1);
        if (!fifo_empty && ((fifo_cnt >= BLEN) || (timer_q == TMO))) begin
          state_d  = ST_BURST;
          len_d    = (fifo_cnt >= BLEN) ? BLEN : fifo_cnt;
          timer_d  = '0;
          issued_d = '0;
          sent_d   = '0;
        end
      end
      ST_BURST: begin
        fifo_rd = !fifo_empty && (issued_q < len_q) && (occ_adj < 2'd2);
        if (fifo_rd) issued_d = issued_q + CNT_W'(1);
        if (beat_acc) begin
          sent_d = sent_q + CNT_W'(1);
          if (sent_q == len_q - CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      inflight_q <= fifo_rd;
    end
  end

  fifo_rd_skid #(.DATA_W(DATA_W)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_last_i (cap_last),
    .push_data_i (fifo_dout),
    .pop_i       (beat_acc),
    .occ_o       (occ),
    .head_data_o (m_data),
    .head_last_o (m_last)
  );
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural sync_fifo model plus a beat scoreboard.
module tb_fifo_burst_reader;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       m_ready = 1'b0;
  logic       fifo_empty;
  logic [3:0] fifo_cnt;
  logic [7:0] fifo_dout = 8'd0;
  logic       fifo_rd, m_valid, m_last, busy;
  logic [7:0] m_data;

  logic [7:0] fifo_q[$];
  logic [7:0] pend_q[$];
  logic [8:0] exp_q[$];
  logic       empty_r = 1'b1;
  logic [3:0] cnt_r = 4'd0;
  bit         gap = 1'b0;

  int checks = 0, errors = 0, cyc = 0;
  int rd_total = 0, rd_first = -1, rd_last = -1, vld_first = -1, last_seen = 0;
  bit rd_seen = 1'b0, prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0] prev_d = 8'd0;
  logic prev_l = 1'b0;

  assign fifo_empty = empty_r | gap;
  assign fifo_cnt   = gap ? 4'd0 : cnt_r;

  fifo_burst_reader #(.DATA_W(8), .CNT_W(4), .BURST_LEN(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_cnt(fifo_cnt),
    .fifo_dout(fifo_dout), .fifo_rd(fifo_rd), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (rd_seen && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
    if (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
    cnt_r   <= 4'(fifo_q.size());
    empty_r <= (fifo_q.size() == 0);
  end

  always @(negedge clk) begin
    logic [8:0] e;
    rd_seen = fifo_rd;
    if (rst) begin
      if (fifo_rd) begin
        checks++;
        if (fifo_empty) begin
          errors++;
          $display("FAIL underflow: fifo_rd=1 while fifo_empty=1 at cycle %0d", cyc);
        end
        if (rd_total == 0) rd_first = cyc;
        rd_last = cyc;
        rd_total++;
      end
      if (m_valid && vld_first < 0) vld_first = cyc;
      if (prev_v && !prev_r) begin
        checks++;
        if ({m_valid, m_last, m_data} !== {1'b1, prev_l, prev_d}) begin
          errors++;
          $display("FAIL hold: got v=%0b last=%0b data=%0h, required v=1 last=%0b data=%0h",
                   m_valid, m_last, m_data, prev_l, prev_d);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat: unexpected beat last=%0b data=%0h", m_last, m_data);
        end else begin
          e = exp_q.pop_front();
          if ({m_last, m_data} !== e) begin
            errors++;
            $display("FAIL beat: got last=%0b data=%0h, required last=%0b data=%0h",
                     m_last, m_data, e[8], e[7:0]);
          end
        end
        if (m_last) last_seen++;
      end
      prev_v = m_valid; prev_r = m_ready; prev_d = m_data; prev_l = m_last;
    end else begin
      prev_v = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    pend_q.push_back(b);
  endtask

  task automatic exp_beat(input logic last, input logic [7:0] d);
    exp_q.push_back({last, d});
  endtask

  task automatic clear_stats();
    rd_total = 0; rd_first = -1; rd_last = -1; vld_first = -1; last_seen = 0;
  endtask

  task automatic wait_drain(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step(1);
      if (exp_q.size() == 0 && pend_q.size() == 0 && !busy && !m_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    step(3);
    checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %0b, required 0", fifo_rd); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b, required 0", m_valid); end
    checks++; if (m_data !== 8'd0) begin errors++; $display("FAIL reset_data: got %0h, required 0", m_data); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %0b, required 0", m_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, required 0", busy); end
    rst = 1'b1;
    step(3);
    checks++; if ({busy, m_valid, fifo_rd} !== 3'b000) begin errors++; $display("FAIL idle_after_reset: got %b, required 000", {busy, m_valid, fifo_rd}); end
  endtask

  task automatic test_single_burst();
    bit ok;
    clear_stats();
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push_byte(8'(i));
      exp_beat(i == 4, 8'(i));
    end
    wait_drain(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst1_done: burst did not complete, exp left %0d", exp_q.size()); end
    checks++; if (rd_total != 4) begin errors++; $display("FAIL burst1_reads: got %0d, required 4", rd_total); end
    checks++; if (rd_last - rd_first != 3) begin errors++; $display("FAIL burst1_rd_span: got %0d, required 3", rd_last - rd_first); end
    checks++; if (vld_first != rd_first + 2) begin errors++; $display("FAIL burst1_latency: got %0d, required %0d", vld_first, rd_first + 2); end
    checks++; if (last_seen != 1) begin errors++; $display("FAIL burst1_lasts: got %0d, required 1", last_seen); end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_stats();
    m_ready = 1'b1;
    push_byte(8'd7);
    exp_beat(1'b1, 8'd7);
    for (int i = 0; i < 10 && fifo_empty; i++) step(1);
    step(16);
    checks++; if (rd_total != 0) begin errors++; $display("FAIL timeout_early: got %0d reads, required 0", rd_total); end
    wait_drain(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL timeout_done: partial burst not delivered, exp left %0d", exp_q.size()); end
    checks++; if (rd_total != 1) begin errors++; $display("FAIL timeout_reads: got %0d, required 1", rd_total); end
  endtask

  task automatic test_ready_toggle();
    bit done;
    clear_stats();
    done = 1'b0;
    m_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      push_byte(8'(10 * i));
      exp_beat(i == 4 || i == 6, 8'(10 * i));
    end
    for (int i = 0; i < 200 && !done; i++) begin
      step(1);
      m_ready = ~m_ready;
      done = (exp_q.size() == 0 && pend_q.size() == 0 && !busy && !m_valid);
    end
    m_ready = 1'b1;
    checks++; if (!done) begin errors++; $display("FAIL toggle_done: exp left %0d", exp_q.size()); end
    checks++; if (last_seen != 2) begin errors++; $display("FAIL toggle_lasts: got %0d, required 2", last_seen); end
    checks++; if (rd_total != 6) begin errors++; $display("FAIL toggle_reads: got %0d, required 6", rd_total); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [3:0] c0;
    clear_stats();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_byte(8'hA0 + 8'(i));
      exp_beat(i == 3, 8'hA0 + 8'(i));
    end
    for (int i = 0; i < 30 && rd_total == 0; i++) step(1);
    step(3);
    c0 = fifo_cnt;
    step(10);
    checks++; if (rd_total > 2 || rd_total == 0) begin errors++; $display("FAIL bp_outstanding: got %0d pops, required 1..2", rd_total); end
    checks++; if (fifo_cnt !== c0) begin errors++; $display("FAIL bp_cnt_stable: got %0d, required %0d", fifo_cnt, c0); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0b, required 1", m_valid); end
    m_ready = 1'b1;
    wait_drain(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_done: exp left %0d", exp_q.size()); end
    checks++; if (rd_total != 4) begin errors++; $display("FAIL bp_reads: got %0d, required 4", rd_total); end
  endtask

  task automatic test_empty_gap();
    bit ok;
    clear_stats();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_byte(8'hC0 + 8'(i));
      exp_beat(i == 3, 8'hC0 + 8'(i));
    end
    for (int i = 0; i < 40 && rd_total < 2; i++) step(1);
    gap = 1'b1;
    checks++; if (rd_total != 2) begin errors++; $display("FAIL gap_start: got %0d reads, required 2", rd_total); end
    step(2);
    checks++; if (rd_total != 2) begin errors++; $display("FAIL gap_reads: got %0d reads during gap, required 2", rd_total); end
    gap = 1'b0;
    wait_drain(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL gap_done: exp left %0d", exp_q.size()); end
    checks++; if (rd_total != 4) begin errors++; $display("FAIL gap_total: got %0d, required 4", rd_total); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    clear_stats();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'h31 + 8'(i));
    for (int i = 0; i < 40 && rd_total < 2; i++) step(1);
    step(2);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    checks++; if ({fifo_rd, m_valid, m_last, busy} !== 4'b0000) begin errors++; $display("FAIL midreset_ctl: got rd/v/last/busy=%b, required 0000", {fifo_rd, m_valid, m_last, busy}); end
    checks++; if (m_data !== 8'd0) begin errors++; $display("FAIL midreset_data: got %0h, required 0", m_data); end
    n = fifo_q.size();
    checks++; if (n != 4) begin errors++; $display("FAIL midreset_fifo: got %0d left, required 4", n); end
    for (int i = 0; i < n; i++) exp_beat(i == n - 1, fifo_q[i]);
    step(2);
    rst = 1'b1;
    clear_stats();
    m_ready = 1'b1;
    wait_drain(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midreset_done: exp left %0d", exp_q.size()); end
    checks++; if (last_seen != 1) begin errors++; $display("FAIL midreset_lasts: got %0d, required 1", last_seen); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_timeout();
    test_ready_toggle();
    test_backpressure();
    test_empty_gap();
    test_reset_mid();
    step(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
